// File: rtl/axi4_boot_mailbox_if.sv
// AXI4 bus bundle between the XDMA host-to-card master and the boot mailbox.
// Only the signals the mailbox uses are carried; burst type and size are implied.
interface axi4_boot_mailbox_if #(
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 64,
  parameter int ID_WIDTH   = 4
);
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic                    awvalid;
  logic                    awready;

  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;

  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic                    arvalid;
  logic                    arready;

  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport slave (
    input  awid, awaddr, awlen, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

  modport master (
    output awid, awaddr, awlen, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );
endinterface

// File: rtl/axi4_boot_mailbox.sv
// AXI4 slave mailbox: all-ones write to CTRL fires a fixed-length start pulse,
// STATUS reports busy / sticky done / boot count back to the host.
module axi4_boot_mailbox #(
  parameter int DATA_WIDTH   = 512,
  parameter int ADDR_WIDTH   = 64,
  parameter int ID_WIDTH     = 4,
  parameter int START_CYCLES = 100
) (
  input  logic                aclk,
  input  logic                areset,
  axi4_boot_mailbox_if.slave  s_axi,
  input  logic                core_done_i,
  output logic                start_o
);

  // Registers occupy one 64-byte beat each; decode on the beat index only.
  localparam int IW = ADDR_WIDTH - 6;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
  typedef enum logic [0:0] {R_IDLE, R_DATA} rstate_e;

  wstate_e             wstate_q, wstate_d;
  logic [ID_WIDTH-1:0] awid_q, awid_d;
  logic [IW-1:0]       widx_q, widx_d;

  rstate_e             rstate_q, rstate_d;
  logic [ID_WIDTH-1:0] arid_q, arid_d;
  logic [IW-1:0]       ridx_q, ridx_d;
  logic [7:0]          arlen_q, arlen_d;
  logic [7:0]          rcnt_q, rcnt_d;
  logic                rlast_q, rlast_d;
  logic [63:0]         rdata_q, rdata_d;

  logic                start_q, start_d;
  logic [15:0]         cnt_q, cnt_d;
  logic                done_q, done_d;
  logic [15:0]         boot_q, boot_d;

  logic                w_hs;
  logic                start_req, start_acc, done_clr;
  logic [63:0]         status;
  logic [7:0]          rcnt_nxt;
  logic [IW-1:0]       ridx_nxt;
  logic                unused_ok;

  assign status = {16'h0, boot_q, 30'h0, done_q, start_q};

  function automatic logic [63:0] reg_rd(input logic [IW-1:0] idx, input logic [63:0] st);
    return (idx == IW'(1)) ? st : 64'h0;
  endfunction

  assign w_hs      = (wstate_q == W_DATA) && s_axi.wvalid;
  assign start_req = w_hs && (widx_q == '0) &&
                     (s_axi.wdata[63:0] == 64'hFFFF_FFFF_FFFF_FFFF) &&
                     (s_axi.wstrb[7:0] == 8'hFF);
  assign start_acc = start_req && !start_q;
  assign done_clr  = start_acc ||
                     (w_hs && (widx_q == IW'(1)) && s_axi.wdata[1] && s_axi.wstrb[0]);

  // Write channel: AW -> W beats until wlast -> single B.
  always_comb begin
    wstate_d = wstate_q;
    awid_d   = awid_q;
    widx_d   = widx_q;
    unique case (wstate_q)
      W_IDLE: if (s_axi.awvalid) begin
        awid_d   = s_axi.awid;
        widx_d   = s_axi.awaddr[ADDR_WIDTH-1:6];
        wstate_d = W_DATA;
      end
      W_DATA: if (s_axi.wvalid) begin
        widx_d = widx_q + IW'(1);
        if (s_axi.wlast) wstate_d = W_RESP;
      end
      W_RESP: if (s_axi.bready) wstate_d = W_IDLE;
      default: wstate_d = W_IDLE;
    endcase
  end

  assign rcnt_nxt = rcnt_q + 8'd1;
  assign ridx_nxt = ridx_q + IW'(1);

  // Read channel: rdata/rlast are registered when a beat is launched so they
  // stay frozen while the host stalls on rready.
  always_comb begin
    rstate_d = rstate_q;
    arid_d   = arid_q;
    ridx_d   = ridx_q;
    arlen_d  = arlen_q;
    rcnt_d   = rcnt_q;
    rlast_d  = rlast_q;
    rdata_d  = rdata_q;
    unique case (rstate_q)
      R_IDLE: if (s_axi.arvalid) begin
        arid_d   = s_axi.arid;
        ridx_d   = s_axi.araddr[ADDR_WIDTH-1:6];
        arlen_d  = s_axi.arlen;
        rcnt_d   = 8'd0;
        rlast_d  = (s_axi.arlen == 8'd0);
        rdata_d  = reg_rd(s_axi.araddr[ADDR_WIDTH-1:6], status);
        rstate_d = R_DATA;
      end
      R_DATA: if (s_axi.rready) begin
        if (rlast_q) begin
          rstate_d = R_IDLE;
        end else begin
          ridx_d  = ridx_nxt;
          rcnt_d  = rcnt_nxt;
          rlast_d = (rcnt_nxt == arlen_q);
          rdata_d = reg_rd(ridx_nxt, status);
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  // Start pulse counts START_CYCLES-1 down to 0; done set beats clear.
  always_comb begin
    start_d = start_q;
    cnt_d   = cnt_q;
    boot_d  = boot_q;
    done_d  = done_q;
    if (start_acc) begin
      start_d = 1'b1;
      cnt_d   = 16'(START_CYCLES - 1);
      boot_d  = boot_q + 16'd1;
    end else if (start_q) begin
      if (cnt_q == 16'd0) start_d = 1'b0;
      else                cnt_d   = cnt_q - 16'd1;
    end
    if (done_clr)    done_d = 1'b0;
    if (core_done_i) done_d = 1'b1;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wstate_q <= W_IDLE;
      awid_q   <= '0;
      widx_q   <= '0;
      rstate_q <= R_IDLE;
      arid_q   <= '0;
      ridx_q   <= '0;
      arlen_q  <= '0;
      rcnt_q   <= '0;
      rlast_q  <= 1'b0;
      rdata_q  <= '0;
      start_q  <= 1'b0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      boot_q   <= '0;
    end else begin
      wstate_q <= wstate_d;
      awid_q   <= awid_d;
      widx_q   <= widx_d;
      rstate_q <= rstate_d;
      arid_q   <= arid_d;
      ridx_q   <= ridx_d;
      arlen_q  <= arlen_d;
      rcnt_q   <= rcnt_d;
      rlast_q  <= rlast_d;
      rdata_q  <= rdata_d;
      start_q  <= start_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      boot_q   <= boot_d;
    end
  end

  assign s_axi.awready = (wstate_q == W_IDLE);
  assign s_axi.wready  = (wstate_q == W_DATA);
  assign s_axi.bvalid  = (wstate_q == W_RESP);
  assign s_axi.bid     = awid_q;
  assign s_axi.bresp   = 2'b00;

  assign s_axi.arready = (rstate_q == R_IDLE);
  assign s_axi.rvalid  = (rstate_q == R_DATA);
  assign s_axi.rid     = arid_q;
  assign s_axi.rdata   = DATA_WIDTH'(rdata_q);
  assign s_axi.rresp   = 2'b00;
  assign s_axi.rlast   = rlast_q;

  assign start_o = start_q;

  // Burst length on AW, sub-beat address bits and upper lanes carry no meaning here.
  assign unused_ok = ^{s_axi.awlen, s_axi.awaddr[5:0], s_axi.araddr[5:0],
                       s_axi.wdata, s_axi.wstrb};

endmodule
